// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: sample and prescaler widths, upsampler
// state encoding and a small helper for "zero means one" control fields.
package dsp_pkg;

    localparam int DATA_W = 13;
    localparam int PSC_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } up_state_t;

    // Factor and prescaler fields treat 0 the same as 1.
    function automatic logic [PSC_W-1:0] at_least_one(input logic [PSC_W-1:0] v);
        return (v == '0) ? PSC_W'(1) : v;
    endfunction

endpackage

// File: rtl/pace_gen.sv
// Prescaler counter: ticks when the count is zero, wraps after max(psc,1)
// clocks, and is held at zero while restart is asserted.
module pace_gen
    import dsp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] psc_cnt;
    logic [PSC_W-1:0] psc_last;

    assign psc_last = at_least_one(psc) - PSC_W'(1);
    assign tick     = (psc_cnt == '0);

    // The >= compare keeps the counter bounded when psc shrinks mid-count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
        end else if (restart || (psc_cnt >= psc_last)) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/up_sample.sv
// Integer-factor upsampler with one-entry skid buffer and paced output.
// Default build zero-stuffs; defining UP_SAMPLE_ZOH_EN selects zero-order hold.
module up_sample #(
    parameter int SYS_CLK_FREQ_MHZ = 50,
    parameter int DATA_W           = dsp_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       up_factor_i,
    input  logic [15:0]       out_psc_i,
    input  logic              raw_data_valid_i,
    output logic              raw_data_ready_o,
    input  logic [DATA_W-1:0] raw_data_i,
    output logic              up_data_valid_o,
    output logic [DATA_W-1:0] up_data_o,
    output logic              busy_o
);
    import dsp_pkg::*;

    if (SYS_CLK_FREQ_MHZ <= 0) begin : g_clk_check
        $error("SYS_CLK_FREQ_MHZ must be positive");
    end

    up_state_t         state;
    logic [DATA_W-1:0] cur_data, buf_data, src_data, emit_data;
    logic [15:0]       cur_l, ph, src_l, src_ph;
    logic              buf_full, accept, idle_acc, tick, emit, last;
    logic              load_in, load_buf, buf_wr, next_idle;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    assign raw_data_ready_o = !buf_full;
    assign busy_o           = (state == EMIT) || buf_full;
    assign up_data_valid_o  = vld_p1;
    assign up_data_o        = data_p1;

    assign accept   = raw_data_valid_i && raw_data_ready_o;
    assign idle_acc = (state == IDLE) && accept;

    // An accept in IDLE emits phase 0 straight from the input so the first
    // strobe appears one cycle after the transfer.
    always_comb begin
        src_data = cur_data;
        src_l    = cur_l;
        src_ph   = ph;
        if (state == IDLE) begin
            src_data = raw_data_i;
            src_l    = at_least_one(up_factor_i);
            src_ph   = '0;
        end
    end

    assign emit     = idle_acc || ((state == EMIT) && tick);
    assign last     = (src_ph == src_l - 16'd1);
    assign load_in  = accept && ((state == IDLE) || (emit && last));
    assign load_buf = (state == EMIT) && emit && last && buf_full;
    assign buf_wr   = accept && !load_in;

`ifdef UP_SAMPLE_ZOH_EN
    assign emit_data = src_data;
`else
    assign emit_data = (src_ph == '0) ? src_data : '0;
`endif

    always_comb begin
        next_idle = 1'b0;
        if (state == IDLE) begin
            next_idle = !(idle_acc && !last);
        end else begin
            next_idle = emit && last && !buf_full && !accept;
        end
    end

    // Held at zero whenever idle, so pacing restarts from the first emission.
    pace_gen u_pace (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (next_idle),
        .psc     (out_psc_i),
        .tick    (tick)
    );

    // Stage p1: control state and registered output strobe/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= '0;
            cur_l    <= '0;
            buf_full <= 1'b0;
            vld_p1   <= 1'b0;
            data_p1  <= '0;
        end else begin
            state   <= next_idle ? IDLE : EMIT;
            vld_p1  <= emit;
            data_p1 <= emit ? emit_data : '0;
            if (load_buf) begin
                cur_l    <= at_least_one(up_factor_i);
                ph       <= '0;
                buf_full <= 1'b0;
            end else if (load_in) begin
                cur_l <= at_least_one(up_factor_i);
                ph    <= ((state == IDLE) && !last) ? 16'd1 : 16'd0;
            end else if (emit) begin
                ph <= last ? 16'd0 : ph + 16'd1;
            end
            if (buf_wr) begin
                buf_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_buf) begin
            cur_data <= buf_data;
        end else if (load_in) begin
            cur_data <= raw_data_i;
        end
        if (buf_wr) begin
            buf_data <= raw_data_i;
        end
    end

endmodule

// File: tb/tb_up_sample.sv
// Self-checking bench for up_sample: vector table, hand sequences and
// randomized streams compared against an output-schedule reference model.
`timescale 1ns/1ps
module tb_up_sample;

    localparam int DW = 13;
`ifdef UP_SAMPLE_ZOH_EN
    localparam bit ZOH = 1'b1;
`else
    localparam bit ZOH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   up_factor_i;
    logic [15:0]   out_psc_i;
    logic          raw_data_valid_i;
    logic          raw_data_ready_o;
    logic [DW-1:0] raw_data_i;
    logic          up_data_valid_o;
    logic [DW-1:0] up_data_o;
    logic          busy_o;

    up_sample #(.SYS_CLK_FREQ_MHZ(50), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .up_factor_i      (up_factor_i),
        .out_psc_i        (out_psc_i),
        .raw_data_valid_i (raw_data_valid_i),
        .raw_data_ready_o (raw_data_ready_o),
        .raw_data_i       (raw_data_i),
        .up_data_valid_o  (up_data_valid_o),
        .up_data_o        (up_data_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { int lbl; int d; } obs_t;
    obs_t obs_q[$];

    // Reference model: cycle label -> expected output sample
    int exp_out[int];
    int prev_last_vis;
    int bl_lo, bl_hi;
    bit mon_en = 1'b0;
    int stall_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int eff(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    function automatic int tail(input int d);
        return ZOH ? d : 0;
    endfunction

    function automatic bit pred_ready();
        return !(cyc >= bl_lo && cyc <= bl_hi);
    endfunction

    task automatic model_reset();
        exp_out.delete();
        prev_last_vis = -1000;
        bl_lo = 1;
        bl_hi = 0;
    endtask

    // Sample accepted at label a: starts one cycle later if the previous
    // sample is done, otherwise exactly one pacing period after its last output.
    task automatic model_accept(input int a, input int d, input int l, input int p);
        int first;
        if (a >= prev_last_vis) begin
            first = a + 1;
        end else begin
            first = prev_last_vis + p;
            if (a < prev_last_vis - 1) begin
                bl_lo = a + 1;
                bl_hi = prev_last_vis - 1;
            end
        end
        for (int k = 0; k < l; k++) exp_out[first + k * p] = (k == 0) ? d : tail(d);
        prev_last_vis = first + (l - 1) * p;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_out.exists(cyc)) begin
                chk("strobe", up_data_valid_o, 1);
                chk("data", up_data_o, exp_out[cyc]);
                exp_out.delete(cyc);
            end else begin
                chk("no_strobe", up_data_valid_o, 0);
                chk("idle_zero", up_data_o, 0);
            end
            if (up_data_valid_o === 1'b1) obs_q.push_back('{cyc, int'(up_data_o)});
        end
    end

    task automatic send(input logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        raw_data_valid_i = 1'b1;
        raw_data_i = d;
        for (int i = 0; i < 200 && !done; i++) begin
            chk("ready", raw_data_ready_o, pred_ready());
            if (!raw_data_ready_o) stall_cycles++;
            if (pred_ready()) begin
                model_accept(cyc, int'(d), eff(up_factor_i), eff(out_psc_i));
                done = 1'b1;
            end
            @(negedge clk);
        end
        raw_data_valid_i = 1'b0;
        raw_data_i = '0;
        if (!done) begin
            failures++;
            $display("FAIL send_timeout: sample 0x%0h not accepted within 200 cycles", d);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cyc <= prev_last_vis && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("busy_idle", busy_o, 0);
        chk("ready_idle", raw_data_ready_o, 1);
        chk("pending_outputs", exp_out.size(), 0);
    endtask

    typedef struct {
        logic [15:0]   l;
        logic [15:0]   p;
        logic [DW-1:0] din;
        int            n_out;
        int            gap;
    } vec_t;
    vec_t vecs[8];

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int a;
        int first_vis;
        logic [DW-1:0] exp_seq[6];

        vecs[0] = '{16'd4, 16'd1, 13'h0123, 4, 1};
        vecs[1] = '{16'd3, 16'd5, 13'h1FFF, 3, 5};
        vecs[2] = '{16'd0, 16'd0, 13'h000A, 1, 1};
        vecs[3] = '{16'd1, 16'd1, 13'h0B0B, 1, 1};
        vecs[4] = '{16'd2, 16'd3, 13'h0ABC, 2, 3};
        vecs[5] = '{16'd5, 16'd0, 13'h1000, 5, 1};
        vecs[6] = '{16'd1, 16'd7, 13'h0FFF, 1, 7};
        vecs[7] = '{16'd0, 16'd2, 13'h1555, 1, 2};

        rst_n = 1'b0;
        up_factor_i = 16'd1;
        out_psc_i = 16'd1;
        raw_data_valid_i = 1'b0;
        raw_data_i = '0;
        stall_cycles = 0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("reset_vld", up_data_valid_o, 0);
        chk("reset_data", up_data_o, 0);
        chk("reset_ready", raw_data_ready_o, 1);
        chk("reset_busy", busy_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Single-sample vectors
        for (int v = 0; v < 8; v++) begin
            up_factor_i = vecs[v].l;
            out_psc_i = vecs[v].p;
            chk("ready_vec", raw_data_ready_o, 1);
            raw_data_valid_i = 1'b1;
            raw_data_i = vecs[v].din;
            a = cyc;
            for (int k = 0; k < vecs[v].n_out; k++)
                exp_out[a + 1 + k * vecs[v].gap] = (k == 0) ? int'(vecs[v].din) : tail(int'(vecs[v].din));
            prev_last_vis = a + 1 + (vecs[v].n_out - 1) * vecs[v].gap;
            @(negedge clk);
            raw_data_valid_i = 1'b0;
            raw_data_i = '0;
            chk("busy_vec", busy_o, (vecs[v].n_out > 1) ? 1 : 0);
            wait_idle();
        end

        // Back-to-back through the skid buffer, L=2 P=2
        model_reset();
        obs_q.delete();
        stall_cycles = 0;
        up_factor_i = 16'd2;
        out_psc_i = 16'd2;
        send(13'h001);
        send(13'h002);
        send(13'h003);
        wait_idle();
        chk("b2b_stalled", (stall_cycles > 0) ? 1 : 0, 1);
        chk("b2b_count", obs_q.size(), 6);
        exp_seq = '{13'h001, 13'h000, 13'h002, 13'h000, 13'h003, 13'h000};
        if (ZOH) exp_seq = '{13'h001, 13'h001, 13'h002, 13'h002, 13'h003, 13'h003};
        for (int i = 0; i < obs_q.size() && i < 6; i++) begin
            chk("b2b_data", obs_q[i].d, exp_seq[i]);
            if (i > 0) chk("b2b_spacing", obs_q[i].lbl - obs_q[i-1].lbl, 2);
        end

        // Continuous stream with L=0 and L=1, P=0
        for (int lv = 0; lv < 2; lv++) begin
            model_reset();
            obs_q.delete();
            stall_cycles = 0;
            up_factor_i = 16'(lv);
            out_psc_i = 16'd0;
            for (int s = 0; s < 8; s++) send(13'(10 + s));
            wait_idle();
            chk("pass_stall", stall_cycles, 0);
            chk("pass_count", obs_q.size(), 8);
            for (int i = 1; i < obs_q.size(); i++) begin
                chk("pass_spacing", obs_q[i].lbl - obs_q[i-1].lbl, 1);
                chk("pass_data", obs_q[i].d, 10 + i);
            end
        end

        // Reset during emission with a sample waiting in the buffer
        model_reset();
        obs_q.delete();
        up_factor_i = 16'd8;
        out_psc_i = 16'd1;
        send(13'h077);
        first_vis = prev_last_vis - 7;
        send(13'h066);
        while (cyc < first_vis + 2) @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", up_data_valid_o, 0);
        chk("midrst_data", up_data_o, 0);
        chk("midrst_ready", raw_data_ready_o, 1);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_seen3", obs_q.size(), 3);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        obs_q.delete();
        mon_en = 1'b1;
        send(13'h055);
        wait_idle();
        chk("postrst_count", obs_q.size(), 8);
        if (obs_q.size() > 0) chk("postrst_first", obs_q[0].d, 13'h055);

        // Factor change while a sample is in flight
        model_reset();
        obs_q.delete();
        up_factor_i = 16'd3;
        out_psc_i = 16'd1;
        send(13'h0AB);
        up_factor_i = 16'd2;
        send(13'h0CD);
        wait_idle();
        chk("latch_count", obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            chk("latch_d0", obs_q[0].d, 13'h0AB);
            chk("latch_d1", obs_q[1].d, tail(13'h0AB));
            chk("latch_d2", obs_q[2].d, tail(13'h0AB));
            chk("latch_d3", obs_q[3].d, 13'h0CD);
            chk("latch_d4", obs_q[4].d, tail(13'h0CD));
        end

        // Randomized bursts against the model
        for (int b = 0; b < 6; b++) begin
            model_reset();
            up_factor_i = 16'($urandom_range(0, 4));
            out_psc_i = 16'($urandom_range(0, 4));
            for (int s = 0; s < 10; s++) begin
                if ($urandom_range(0, 2) == 0)
                    repeat ($urandom_range(1, eff(up_factor_i) * eff(out_psc_i) + 2)) @(negedge clk);
                send(13'($urandom));
            end
            wait_idle();
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/up_sample.md
Name: up_sample

Overview:
Integer-factor upsampler for the 13-bit raw sample stream. It is the transmit-side counterpart to the receive-side decimator. Each accepted input sample is expanded into L output samples, paced by a programmable clock prescaler. Default mode is zero-stuffing, which feeds an interpolation FIR; an optional build mode is zero-order hold. Sits between the sample source (pattern/DSP core) and the DAC/test-pattern path.

Parameters:
SYS_CLK_FREQ_MHZ, 50, system clock frequency; informational only, no logic depends on it
DATA_W, 13, sample width in bits

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
up_factor_i  in  16  interpolation factor L; 0 treated as 1
out_psc_i  in  16  output pacing: one output every out_psc_i clocks; 0 or 1 means every clock
raw_data_valid_i  in  1  input sample valid
raw_data_ready_o  in  out  1  input ready; transfer occurs when valid && ready
raw_data_i  in  13  input sample
up_data_valid_o  out  1  one-cycle strobe per output sample
up_data_o  out  13  output sample; 0 whenever up_data_valid_o is low
busy_o  out  1  high while in EMIT state or while the skid buffer is full

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low on rst_n.
- Reset values:
  - up_data_valid_o = 0, up_data_o = 0, busy_o = 0, raw_data_ready_o = 1
  - State = IDLE; all counters = 0; buffer empty
- Storage:
  - Current register: cur_data, cur_L (latched factor), phase counter ph[15:0].
  - One-entry skid buffer: buf_data, buf_full.
- raw_data_ready_o = !buf_full. This is combinational from registered state only, with no path from valid.
- up_factor_i is latched per sample, when the sample is loaded into the current register. Mid-stream changes affect only later samples.
- out_psc_i is read live.
- FSM states:
  - IDLE: on accept, load cur_data/cur_L, set ph = 0 and psc_cnt = 0, go to EMIT. The input bypasses the buffer.
  - EMIT: an emission occurs on a cycle where psc_cnt == 0.
    - psc_cnt counts 0..max(out_psc_i,1)-1, then wraps.
    - Emission registers valid = 1 and data = cur_data if ph == 0, else 0.
    - ph increments after each emission.
- Last emission (ph == cur_L-1):
  - If buf_full: load the buffer into current, clear buf_full, ph = 0, psc_cnt restarts at 0, stay in EMIT.
  - Else, if an accept occurs the same cycle: load the input directly into current, stay in EMIT.
  - Else: go to IDLE.
- Accepts in EMIT on any other cycle write the skid buffer.
- A gapless input stream at rate 1/(L·P) is sustained without ready deassertion gaps beyond one buffer slot.
- Latency: an accept in IDLE at cycle T gives the first up_data_valid_o at T+1. All outputs are registered.
- Output spacing is exactly max(out_psc_i,1) cycles, including across sample boundaries.
- L = 1 with P = 1 gives a pass-through with 1-cycle latency and full throughput.
- Reset asserted mid-operation: state is lost immediately, outputs go to 0, the buffered sample is discarded.

Optional Feature:
- Macro: UP_SAMPLE_ZOH_EN.
- Defined: every emission outputs cur_data (zero-order hold). Phase logic is unchanged.
- Undefined: zero-stuffing as described above.
- Port list is identical in both builds.

Decomposition:
- Shared package dsp_pkg: DATA_W = 13, PSC_W = 16, and state encoding localparams IDLE = 1'b0, EMIT = 1'b1.
- One natural sub-module: pace_gen. It is a prescaler counter with a restart input that outputs a tick when psc_cnt == 0. It can be reused by the decimator-side rate logic.
- The remainder (FSM, skid buffer, output register) stays in up_sample.

Test Plan:
1. Zero-stuffing, L=4, P=1: send 0x0123 → valid on 4 consecutive cycles with data 0x0123, 0, 0, 0, starting 1 cycle after the accept. Then IDLE, busy_o = 0.
2. Pacing, L=3, P=5: send 0x1FFF → valids at T+1, T+6, T+11 with data 0x1FFF, 0, 0. up_data_o = 0 between strobes.
3. Back-to-back with buffer, L=2, P=2: valid held high with 0x001, 0x002, 0x003.
   - ready drops to 0 once the buffer fills.
   - Outputs: 1, 0, 2, 0, 3, 0, each spaced exactly 2 cycles, with no gap at sample boundaries.
4. Edge factors: L=0 or L=1 with P=0 and a continuous stream 0x00A, 0x00B, ... → one output per clock, 1-cycle latency, ready stays 1.
5. Mid-operation reset, L=8: assert rst_n low after the 3rd output → outputs immediately 0, ready = 1. After release, a new sample 0x055 restarts at ph = 0.
6. ZOH build (UP_SAMPLE_ZOH_EN), L=3, P=1: send 0x0AB → three outputs, all 0x0AB. Change up_factor_i to 2 mid-sample → that sample still emits 3 outputs, the next sample emits 2.
